// File: rtl/serial_endpoint.sv
// Device-side partner of the CPU memory-mapped serial port: an RX byte FIFO fed by the host,
// and a TX byte FIFO drained by an 8N1 UART transmitter.
//
// UART FSM states:
//   state    | meaning
//   ST_IDLE  | line high; pops the TX FIFO head when one is waiting
//   ST_START | start bit (low) for CLKS_PER_BIT cycles
//   ST_DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
//   ST_STOP  | stop bit (high) for CLKS_PER_BIT cycles
module serial_endpoint #(
    parameter int RX_DEPTH     = 8,
    parameter int TX_DEPTH     = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] host_wr_data,
    input  logic       host_wr_en,
    output logic       host_full,
    output logic [7:0] cpu_data_out,
    output logic       cpu_valid_out,
    input  logic       cpu_rden_in,
    input  logic [7:0] cpu_data_in,
    input  logic       cpu_wren_in,
    output logic       cpu_ready_out,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       rx_underflow,
    output logic       tx_overflow
);

    localparam int RX_AW  = $clog2(RX_DEPTH);
    localparam int RX_CW  = RX_AW + 1;
    localparam int TX_AW  = $clog2(TX_DEPTH);
    localparam int TX_CW  = TX_AW + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [RX_CW-1:0]  RX_FULL   = RX_CW'(RX_DEPTH);
    localparam logic [TX_CW-1:0]  TX_FULL   = TX_CW'(TX_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    // RX FIFO
    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] r_rx_rd_ptr;
    logic [RX_AW-1:0] r_rx_wr_ptr;
    logic [RX_CW-1:0] r_rx_count;
    logic             r_rx_underflow;
    logic             w_rx_empty;
    logic             w_rx_pop;
    logic             w_rx_push;

    assign w_rx_empty = (r_rx_count == '0);
    assign w_rx_pop   = cpu_rden_in && !w_rx_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
    assign w_rx_push  = host_wr_en && ((r_rx_count != RX_FULL) || w_rx_pop);

    always_ff @(posedge clock) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= host_wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_rd_ptr    <= '0;
            r_rx_wr_ptr    <= '0;
            r_rx_count     <= '0;
            r_rx_underflow <= 1'b0;
        end else begin
            if (w_rx_push) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + RX_AW'(1);
            end
            if (w_rx_pop) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + RX_AW'(1);
            end
            if (w_rx_push && !w_rx_pop) begin
                r_rx_count <= r_rx_count + RX_CW'(1);
            end else if (!w_rx_push && w_rx_pop) begin
                r_rx_count <= r_rx_count - RX_CW'(1);
            end
            if (cpu_rden_in && w_rx_empty) begin
                r_rx_underflow <= 1'b1;
            end
        end
    end

    assign cpu_data_out  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd_ptr];
    assign cpu_valid_out = !w_rx_empty;
    assign host_full     = (r_rx_count == RX_FULL);
    assign rx_underflow  = r_rx_underflow;

    // TX FIFO
    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] r_tx_rd_ptr;
    logic [TX_AW-1:0] r_tx_wr_ptr;
    logic [TX_CW-1:0] r_tx_count;
    logic             r_tx_overflow;
    logic             w_tx_empty;
    logic             w_tx_ready;
    logic             w_tx_push;
    logic             w_tx_pop;

    assign w_tx_empty = (r_tx_count == '0);
    assign w_tx_ready = (r_tx_count != TX_FULL);
    assign w_tx_push  = cpu_wren_in && w_tx_ready;

    always_ff @(posedge clock) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= cpu_data_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_rd_ptr   <= '0;
            r_tx_wr_ptr   <= '0;
            r_tx_count    <= '0;
            r_tx_overflow <= 1'b0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + TX_AW'(1);
            end
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + TX_AW'(1);
            end
            if (w_tx_push && !w_tx_pop) begin
                r_tx_count <= r_tx_count + TX_CW'(1);
            end else if (!w_tx_push && w_tx_pop) begin
                r_tx_count <= r_tx_count - TX_CW'(1);
            end
            if (cpu_wren_in && !w_tx_ready) begin
                r_tx_overflow <= 1'b1;
            end
        end
    end

    assign cpu_ready_out = w_tx_ready;
    assign tx_overflow   = r_tx_overflow;

    // UART transmitter
    uart_state_t       r_state;
    uart_state_t       w_state_next;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_txd;
    logic              w_txd_next;
    logic              w_baud_tc;

    assign w_baud_tc = (r_baud_cnt == '0);

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud_cnt;
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_txd_next   = 1'b1;
        w_tx_pop     = 1'b0;
        if (r_state != ST_IDLE) begin
            w_baud_next = w_baud_tc ? BAUD_LAST : r_baud_cnt - BAUD_W'(1);
        end
        // The line value is computed for the next state so uart_txd comes straight from a flop.
        case (r_state)
            ST_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop     = 1'b1;
                    w_shift_next = r_tx_mem[r_tx_rd_ptr];
                    w_baud_next  = BAUD_LAST;
                    w_state_next = ST_START;
                    w_txd_next   = 1'b0;
                end
            end
            ST_START: begin
                w_txd_next = 1'b0;
                if (w_baud_tc) begin
                    w_state_next = ST_DATA;
                    w_bit_next   = 3'd0;
                    w_txd_next   = r_shift[0];
                end
            end
            ST_DATA: begin
                w_txd_next = r_shift[0];
                if (w_baud_tc) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = ST_STOP;
                        w_txd_next   = 1'b1;
                    end else begin
                        w_shift_next = r_shift >> 1;
                        w_bit_next   = r_bit_idx + 3'd1;
                        w_txd_next   = r_shift[1];
                    end
                end
            end
            ST_STOP: begin
                if (w_baud_tc) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_idx  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_txd      <= w_txd_next;
        end
    end

    assign uart_txd = r_txd;
    assign tx_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_endpoint.sv
// Directed bench for serial_endpoint: RX FIFO ordering/flags, UART framing, TX back-pressure,
// and reset in the middle of a frame. Runs with CLKS_PER_BIT=4.
module tb_serial_endpoint;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] host_wr_data = 8'h00;
    logic       host_wr_en = 1'b0;
    logic       host_full;
    logic [7:0] cpu_data_out;
    logic       cpu_valid_out;
    logic       cpu_rden_in = 1'b0;
    logic [7:0] cpu_data_in = 8'h00;
    logic       cpu_wren_in = 1'b0;
    logic       cpu_ready_out;
    logic       uart_txd;
    logic       tx_busy;
    logic       rx_underflow;
    logic       tx_overflow;

    int checks   = 0;
    int failures = 0;

    serial_endpoint #(
        .RX_DEPTH    (8),
        .TX_DEPTH    (8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .host_wr_data (host_wr_data),
        .host_wr_en   (host_wr_en),
        .host_full    (host_full),
        .cpu_data_out (cpu_data_out),
        .cpu_valid_out(cpu_valid_out),
        .cpu_rden_in  (cpu_rden_in),
        .cpu_data_in  (cpu_data_in),
        .cpu_wren_in  (cpu_wren_in),
        .cpu_ready_out(cpu_ready_out),
        .uart_txd     (uart_txd),
        .tx_busy      (tx_busy),
        .rx_underflow (rx_underflow),
        .tx_overflow  (tx_overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected line level rel cycles after the start bit begins (rel in 0..FRAME-1).
    function automatic logic frame_bit(input logic [7:0] b, input int rel);
        if (rel < CPB) return 1'b0;
        if (rel < 9 * CPB) return b[(rel - CPB) / CPB];
        return 1'b1;
    endfunction

    // Write one byte into an idle, empty TX path and check the whole frame plus the idle after it.
    task automatic send_single(input logic [7:0] b);
        for (int n = 0; n <= FRAME + 1; n++) begin
            cpu_wren_in = (n == 0);
            cpu_data_in = b;
            tick();
            cpu_wren_in = 1'b0;
            if (n == 0) begin
                chk("single_pre_txd", 32'(uart_txd), 32'h1);
                chk("single_pre_busy", 32'(tx_busy), 32'h0);
            end else if (n - 1 < FRAME) begin
                chk("single_txd", 32'(uart_txd), 32'(frame_bit(b, n - 1)));
                chk("single_busy", 32'(tx_busy), 32'h1);
            end else begin
                chk("single_idle_txd", 32'(uart_txd), 32'h1);
                chk("single_idle_busy", 32'(tx_busy), 32'h0);
            end
        end
    endtask

    logic [7:0] tx_bytes [10] = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'hFF,
                                  8'h00, 8'h3C, 8'hC3, 8'h96, 8'hEE};

    initial begin
        tick();
        tick();
        chk("rst_valid", 32'(cpu_valid_out), 32'h0);
        chk("rst_data", 32'(cpu_data_out), 32'h0);
        chk("rst_full", 32'(host_full), 32'h0);
        chk("rst_ready", 32'(cpu_ready_out), 32'h1);
        chk("rst_txd", 32'(uart_txd), 32'h1);
        chk("rst_busy", 32'(tx_busy), 32'h0);
        chk("rst_udf", 32'(rx_underflow), 32'h0);
        chk("rst_ovf", 32'(tx_overflow), 32'h0);
        reset = 1'b0;
        tick();

        // RX: two bytes in, popped in order
        host_wr_en = 1'b1;
        host_wr_data = 8'h41;
        tick();
        host_wr_data = 8'h42;
        tick();
        host_wr_en = 1'b0;
        chk("rx_valid_2", 32'(cpu_valid_out), 32'h1);
        chk("rx_head_41", 32'(cpu_data_out), 32'h41);
        cpu_rden_in = 1'b1;
        tick();
        cpu_rden_in = 1'b0;
        chk("rx_head_42", 32'(cpu_data_out), 32'h42);
        chk("rx_valid_1", 32'(cpu_valid_out), 32'h1);
        cpu_rden_in = 1'b1;
        tick();
        cpu_rden_in = 1'b0;
        chk("rx_valid_0", 32'(cpu_valid_out), 32'h0);
        chk("rx_data_0", 32'(cpu_data_out), 32'h0);
        chk("rx_udf_clear", 32'(rx_underflow), 32'h0);

        // RX underflow
        cpu_rden_in = 1'b1;
        tick();
        cpu_rden_in = 1'b0;
        chk("rx_udf_set", 32'(rx_underflow), 32'h1);
        chk("rx_udf_valid", 32'(cpu_valid_out), 32'h0);

        // RX fill to full, drop on full, push+pop on full
        for (int i = 0; i < 8; i++) begin
            host_wr_en = 1'b1;
            host_wr_data = 8'h10 + 8'(i);
            tick();
            if (i == 6) chk("rx_not_full_7", 32'(host_full), 32'h0);
        end
        chk("rx_full", 32'(host_full), 32'h1);
        chk("rx_full_head", 32'(cpu_data_out), 32'h10);
        host_wr_data = 8'h99;
        tick();
        chk("rx_drop_full", 32'(host_full), 32'h1);
        host_wr_data = 8'h18;
        cpu_rden_in = 1'b1;
        tick();
        host_wr_en = 1'b0;
        cpu_rden_in = 1'b0;
        chk("rx_pp_full", 32'(host_full), 32'h1);
        chk("rx_pp_head", 32'(cpu_data_out), 32'h11);
        for (int i = 0; i < 8; i++) begin
            chk("rx_drain", 32'(cpu_data_out), 32'h11 + 32'(i));
            cpu_rden_in = 1'b1;
            tick();
            cpu_rden_in = 1'b0;
        end
        chk("rx_drained", 32'(cpu_valid_out), 32'h0);

        // push+pop on empty: push wins, count becomes 1
        host_wr_en = 1'b1;
        host_wr_data = 8'h5E;
        cpu_rden_in = 1'b1;
        tick();
        host_wr_en = 1'b0;
        cpu_rden_in = 1'b0;
        chk("rx_pp_empty_valid", 32'(cpu_valid_out), 32'h1);
        chk("rx_pp_empty_head", 32'(cpu_data_out), 32'h5E);
        cpu_rden_in = 1'b1;
        tick();
        cpu_rden_in = 1'b0;
        chk("rx_pp_empty_pop", 32'(cpu_valid_out), 32'h0);

        // TX: single 0xA5 frame
        send_single(8'hA5);

        // TX: nine back-to-back writes plus one overflow attempt
        for (int n = 0; n < 1 + 41 * 9; n++) begin
            cpu_wren_in = (n <= 9);
            cpu_data_in = tx_bytes[n > 9 ? 9 : n];
            tick();
            cpu_wren_in = 1'b0;
            if (n == 7) chk("b2b_ready_7", 32'(cpu_ready_out), 32'h1);
            if (n == 8) begin
                chk("b2b_ready_8", 32'(cpu_ready_out), 32'h0);
                chk("b2b_ovf_clear", 32'(tx_overflow), 32'h0);
            end
            if (n == 9) chk("b2b_ovf_set", 32'(tx_overflow), 32'h1);
            if (n >= 1) begin
                if ((n - 1) % 41 < FRAME) begin
                    chk("b2b_txd", 32'(uart_txd), 32'(frame_bit(tx_bytes[(n - 1) / 41], (n - 1) % 41)));
                    chk("b2b_busy", 32'(tx_busy), 32'h1);
                end else begin
                    chk("b2b_gap_txd", 32'(uart_txd), 32'h1);
                    chk("b2b_gap_busy", 32'(tx_busy), 32'h0);
                end
            end
        end
        chk("b2b_ready_end", 32'(cpu_ready_out), 32'h1);

        // Reset during data bit 3 of 0x3C, with more bytes still queued on both sides
        host_wr_en = 1'b1;
        host_wr_data = 8'h66;
        tick();
        host_wr_en = 1'b0;
        for (int n = 0; n <= 18; n++) begin
            cpu_wren_in = (n <= 1);
            cpu_data_in = (n == 0) ? 8'h3C : 8'h77;
            tick();
            cpu_wren_in = 1'b0;
        end
        chk("mid_busy", 32'(tx_busy), 32'h1);
        chk("mid_txd_bit3", 32'(uart_txd), 32'(frame_bit(8'h3C, 17)));
        reset = 1'b1;
        #1;
        chk("arst_txd", 32'(uart_txd), 32'h1);
        chk("arst_busy", 32'(tx_busy), 32'h0);
        chk("arst_ready", 32'(cpu_ready_out), 32'h1);
        chk("arst_valid", 32'(cpu_valid_out), 32'h0);
        chk("arst_data", 32'(cpu_data_out), 32'h0);
        chk("arst_udf", 32'(rx_underflow), 32'h0);
        chk("arst_ovf", 32'(tx_overflow), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("post_rst_txd", 32'(uart_txd), 32'h1);
            chk("post_rst_busy", 32'(tx_busy), 32'h0);
        end
        send_single(8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
